sprite_draw_datapath: RTL

SPRITE_DRAW_DATAPATH -- requirements
Module: sprite_draw_datapath

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_pixel_counter.sv | 57 +++++
 rtl/sprite_draw_datapath.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and default sizing for the sprite draw datapath.
package sprite_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StDone
  } state_e;

  localparam int unsigned DEF_X_W      = 8;
  localparam int unsigned DEF_Y_W      = 7;
  localparam int unsigned DEF_COL_W    = 3;
  localparam int unsigned DEF_NUM_OBJ  = 2;
  localparam int unsigned DEF_SPR_W    = 4;
  localparam int unsigned DEF_SPR_H    = 4;
  localparam int unsigned DEF_SCREEN_W = 160;
  localparam int unsigned DEF_SCREEN_H = 120;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int unsigned cnt_w(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_pixel_counter.sv
// Raster offset counter over one sprite: px runs fastest, py steps when px wraps.
module sprite_pixel_counter
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W = DEF_SPR_W,
  parameter int unsigned SPR_H = DEF_SPR_H,
  parameter int unsigned PX_W  = cnt_w(SPR_W),
  parameter int unsigned PY_W  = cnt_w(SPR_H)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            advance,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic            wrap
);

  logic [PX_W-1:0] px_q, px_d;
  logic [PY_W-1:0] py_q, py_d;
  logic            px_last, py_last;

  assign px_last = (px_q == PX_W'(SPR_W - 1));
  assign py_last = (py_q == PY_W'(SPR_H - 1));

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (clear) begin
      px_d = '0;
      py_d = '0;
    end else if (advance) begin
      if (px_last) begin
        px_d = '0;
        py_d = py_last ? '0 : py_q + PY_W'(1);
      end else begin
        px_d = px_q + PX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign px   = px_q;
  assign py   = py_q;
  // Carry-out: the pixel being stepped over is the last one of the sprite.
  assign wrap = advance && px_last && py_last;

endmodule

// File: rtl/sprite_draw_datapath.sv
// Walks every object's sprite in raster order and emits one registered pixel per cycle.
// Define CLIP_EN to suppress plot for pixels outside SCREEN_W x SCREEN_H.
module sprite_draw_datapath
  import sprite_pkg::*;
#(
  parameter int unsigned X_W      = DEF_X_W,
  parameter int unsigned Y_W      = DEF_Y_W,
  parameter int unsigned COL_W    = DEF_COL_W,
  parameter int unsigned NUM_OBJ  = DEF_NUM_OBJ,
  parameter int unsigned SPR_W    = DEF_SPR_W,
  parameter int unsigned SPR_H    = DEF_SPR_H,
  parameter int unsigned SCREEN_W = DEF_SCREEN_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_OBJ*X_W-1:0]   obj_x,
  input  logic [NUM_OBJ*Y_W-1:0]   obj_y,
  input  logic [NUM_OBJ*COL_W-1:0] obj_col,
  input  logic [NUM_OBJ-1:0]       obj_en,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [COL_W-1:0]         col_out,
  output logic                     plot,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned IDX_W = cnt_w(NUM_OBJ);
  localparam int unsigned PX_W  = cnt_w(SPR_W);
  localparam int unsigned PY_W  = cnt_w(SPR_H);

`ifdef CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  state_e state_q, state_d;

  logic [NUM_OBJ*X_W-1:0]   obj_x_q, obj_x_d;
  logic [NUM_OBJ*Y_W-1:0]   obj_y_q, obj_y_d;
  logic [NUM_OBJ*COL_W-1:0] obj_col_q, obj_col_d;
  logic [NUM_OBJ-1:0]       obj_en_q, obj_en_d;
  logic [IDX_W-1:0]         idx_q, idx_d;

  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic            cnt_clear, cnt_adv, cnt_wrap;
  logic [PX_W-1:0] px;
  logic [PY_W-1:0] py;

  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic [COL_W-1:0] cur_col;
  logic             cur_en;
  logic [X_W:0]     x_sum;
  logic [Y_W:0]     y_sum;
  logic             off_screen;
  logic             pix_plot;

  sprite_pixel_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .PX_W  (PX_W),
    .PY_W  (PY_W)
  ) u_pixel_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (cnt_adv),
    .px      (px),
    .py      (py),
    .wrap    (cnt_wrap)
  );

  always_comb begin
    cur_x   = '0;
    cur_y   = '0;
    cur_col = '0;
    cur_en  = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_x   = obj_x_q[i*X_W +: X_W];
        cur_y   = obj_y_q[i*Y_W +: Y_W];
        cur_col = obj_col_q[i*COL_W +: COL_W];
        cur_en  = obj_en_q[i];
      end
    end
  end

  // One guard bit so clipping sees the true sum; outputs keep only the low bits.
  assign x_sum      = {1'b0, cur_x} + (X_W + 1)'(px);
  assign y_sum      = {1'b0, cur_y} + (Y_W + 1)'(py);
  assign off_screen = (32'(x_sum) >= SCREEN_W) || (32'(y_sum) >= SCREEN_H);
  assign pix_plot   = cur_en && !(CLIP_ON && off_screen);

  always_comb begin
    state_d   = state_q;
    obj_x_d   = obj_x_q;
    obj_y_d   = obj_y_q;
    obj_col_d = obj_col_q;
    obj_en_d  = obj_en_q;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    col_d     = col_q;
    plot_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_adv   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          obj_x_d   = obj_x;
          obj_y_d   = obj_y;
          obj_col_d = obj_col;
          obj_en_d  = obj_en;
          idx_d     = '0;
          cnt_clear = 1'b1;
          busy_d    = 1'b1;
          state_d   = StDraw;
        end
      end
      StDraw: begin
        x_d     = x_sum[X_W-1:0];
        y_d     = y_sum[Y_W-1:0];
        col_d   = cur_col;
        plot_d  = pix_plot;
        cnt_adv = 1'b1;
        if (cnt_wrap) begin
          if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      obj_x_q   <= '0;
      obj_y_q   <= '0;
      obj_col_q <= '0;
      obj_en_q  <= '0;
      idx_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      obj_x_q   <= obj_x_d;
      obj_y_q   <= obj_y_d;
      obj_col_q <= obj_col_d;
      obj_en_q  <= obj_en_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      col_q     <= col_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x_out   = x_q;
  assign y_out   = y_q;
  assign col_out = col_q;
  assign plot    = plot_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
